adaptive_phase_controller: RTL and testbench
============================================

// Module: adaptive_phase_controller
// PURPOSE
//   Parametrised N-phase adaptive traffic light controller, successor to the fixed 4-approach FSM.
//   Serves phases round-robin, skipping phases with no demand; each visit is GREEN -> YELLOW -> ALL_RED.
//   Green time is timed between MIN_GREEN and MAX_GREEN; congestion extends it up to MAX_GREEN.
//   Sits between the lane sensor front-end and the lamp drivers. All timing is counted in 'tick' strobes.
// PARAMETERS
//   N_PHASES   4   number of signal phases (>=2)
//   CNT_W      8   width of the tick timer; every duration below must be < 2**CNT_W
//   MIN_GREEN  10  minimum green duration, ticks (>=1)
//   MAX_GREEN  40  maximum green duration, ticks (>=MIN_GREEN)
//   YELLOW_T   3   yellow duration, ticks (>=1)
//   ALLRED_T   2   all-red clearance duration, ticks (>=1)
// PORTS
//   clk          in   1                  system clock
//   rst          in   1                  reset, synchronous, active-high
//   tick         in   1                  timing strobe, one clk wide; timers advance only when high
//   demand       in   N_PHASES           start-of-lane sensor per phase (vehicle waiting)
//   congest      in   N_PHASES           congestion sensor per phase
//   fsm_state    out  2                  0=ALL_RED, 1=GREEN, 2=YELLOW
//   active_phase out  $clog2(N_PHASES)   phase being served, or last served in ALL_RED
//   lights       out  3*N_PHASES         per phase p, bits [3p+2:3p] = {Y,G,R}: 001 red, 010 green, 100 yellow
//   green_ext    out  1                  high in GREEN once timer >= MIN_GREEN (green held by congestion)
//   phase_start  out  1                  one-cycle pulse, the cycle after entry to GREEN
// BEHAVIOUR
//   - Reset (sync, wins over tick): fsm_state=ALL_RED, timer=0, active_phase=N_PHASES-1,
//     phase_start=0, green_ext=0, all lights=001. The first search therefore starts at phase 0.
//   - timer holds the number of ticks elapsed in the current state. On tick, t1 = timer+1.
//     No tick: state and timer hold. Every transition clears timer to 0.
//   - ALL_RED, on tick:
//     - If t1 >= ALLRED_T and some demand bit is set: go to GREEN.
//       The new active_phase is the first p with demand[p]=1, searching active_phase+1, +2, ... with
//       modulo-N_PHASES wrap, and active_phase itself last.
//     - Otherwise timer = min(t1, ALLRED_T) (saturates) and the state stays ALL_RED. Demand is
//       re-evaluated on every tick.
//   - GREEN, on tick: go to YELLOW when t1 >= MIN_GREEN and (congest[active_phase]==0 or t1 >= MAX_GREEN).
//     Otherwise timer = t1. Only the active phase's congest bit matters. Demand on other phases never
//     preempts the green.
//   - YELLOW, on tick: go to ALL_RED when t1 == YELLOW_T.
//   - fsm_state, active_phase and timer are registered. lights and green_ext decode combinationally from
//     the registered state. Non-active phases are always 001. In ALL_RED every phase is 001.
//   - phase_start is a register, set to 1 for exactly the cycle after the ALL_RED->GREEN edge.
//   - demand and congest are sampled only on tick cycles. Changes between ticks have no effect.
//   - Unencoded fsm_state (3): next cycle goes to ALL_RED with timer=0. active_phase is unchanged.
//   - Elaboration check: $error if MIN_GREEN > MAX_GREEN, if any duration is 0, or if any duration
//     is >= 2**CNT_W.
//   - Reset mid-operation (any state, any timer value): reset values on the next clk edge.
//     No yellow is forced.
// TESTING  (N_PHASES=4, MIN_GREEN=4, MAX_GREEN=8, YELLOW_T=2, ALLRED_T=1, tick=1 each cycle unless noted)
//   1. Reset, demand=0 for 20 cycles -> ALL_RED throughout, lights=12'h249. Then demand=4'b0100 ->
//      next edge GREEN, active_phase=2, phase_start pulses once.
//   2. demand[0]=1, congest=0 -> green exactly 4 cycles, yellow 2, all-red 1. Phase-0 lights
//      sequence 010,100,001.
//   3. congest[0]=1 held -> green_ext high from green cycle 5. Yellow after exactly 8 green cycles.
//   4. demand=4'b1011 with active_phase=1 -> served order is 3, 0, 1, 3. Phase 2 is never green.
//   5. rst asserted on green cycle 2 -> next edge ALL_RED, active_phase=3, timer=0, all lights=001.
//   6. tick every 3rd cycle -> all durations scale x3. With tick held low, state and timer are frozen.

Source files
------------

// File: rtl/adaptive_phase_controller.sv
// N-phase adaptive traffic light controller: round-robin service of phases with demand,
// GREEN -> YELLOW -> ALL_RED per visit, green stretched by congestion up to MAX_GREEN.
module adaptive_phase_controller #(
  parameter int N_PHASES  = 4,
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [N_PHASES-1:0]           demand,
  input  logic [N_PHASES-1:0]           congest,
  output logic [1:0]                    fsm_state,
  output logic [$clog2(N_PHASES)-1:0]   active_phase,
  output logic [3*N_PHASES-1:0]         lights,
  output logic                          green_ext,
  output logic                          phase_start
);

  // state    | meaning
  // ALL_RED  | clearance, every lamp red; next phase chosen here
  // GREEN    | active phase green, timed MIN_GREEN..MAX_GREEN
  // YELLOW   | active phase yellow for YELLOW_T ticks
  // 3        | unencoded, recovers to ALL_RED

  localparam int PW = $clog2(N_PHASES);

  localparam logic [1:0] ST_ALL_RED = 2'd0;
  localparam logic [1:0] ST_GREEN   = 2'd1;
  localparam logic [1:0] ST_YELLOW  = 2'd2;

  localparam logic [CNT_W:0] MIN_G = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0] MAX_G = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0] YEL_T = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0] AR_T  = (CNT_W+1)'(ALLRED_T);

  if (N_PHASES < 2 || MIN_GREEN > MAX_GREEN || MIN_GREEN < 1 || YELLOW_T < 1 || ALLRED_T < 1 ||
      MAX_GREEN >= (1 << CNT_W) || YELLOW_T >= (1 << CNT_W) || ALLRED_T >= (1 << CNT_W)) begin : g_bad_param
    $error("adaptive_phase_controller: illegal timing parameters");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             phase_start_q, phase_start_d;

  logic [CNT_W:0]   t1;
  logic [PW-1:0]    next_phase;
  logic             found;
  int               cand;
  logic [2:0]       lamp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ALL_RED;
      timer_q       <= '0;
      phase_q       <= PW'(N_PHASES - 1);
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      phase_q       <= phase_d;
      phase_start_q <= phase_start_d;
    end
  end

  // Round-robin search starting after the current phase, current phase checked last.
  always_comb begin
    next_phase = phase_q;
    found      = 1'b0;
    cand       = 0;
    for (int k = 1; k <= N_PHASES; k++) begin
      cand = int'(phase_q) + k;
      if (cand >= N_PHASES) cand = cand - N_PHASES;
      if (!found && demand[PW'(cand)]) begin
        found      = 1'b1;
        next_phase = PW'(cand);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    phase_d = phase_q;
    t1      = {1'b0, timer_q} + {{CNT_W{1'b0}}, 1'b1};
    case (state_q)
      ST_ALL_RED: begin
        if (tick) begin
          if (t1 >= AR_T && found) begin
            state_d = ST_GREEN;
            timer_d = '0;
            phase_d = next_phase;
          end else if (t1 >= AR_T) begin
            timer_d = AR_T[CNT_W-1:0];
          end else begin
            timer_d = t1[CNT_W-1:0];
          end
        end
      end
      ST_GREEN: begin
        if (tick) begin
          if (t1 >= MIN_G && (!congest[phase_q] || t1 >= MAX_G)) begin
            state_d = ST_YELLOW;
            timer_d = '0;
          end else begin
            timer_d = t1[CNT_W-1:0];
          end
        end
      end
      ST_YELLOW: begin
        if (tick) begin
          if (t1 == YEL_T) begin
            state_d = ST_ALL_RED;
            timer_d = '0;
          end else begin
            timer_d = t1[CNT_W-1:0];
          end
        end
      end
      default: begin
        state_d = ST_ALL_RED;
        timer_d = '0;
      end
    endcase
    phase_start_d = (state_q == ST_ALL_RED) && (state_d == ST_GREEN);
  end

  always_comb begin
    lamp      = 3'b001;
    green_ext = 1'b0;
    case (state_q)
      ST_GREEN: begin
        lamp      = 3'b010;
        green_ext = ({1'b0, timer_q} >= MIN_G);
      end
      ST_YELLOW: lamp = 3'b100;
      default:   lamp = 3'b001;
    endcase
  end

  for (genvar p = 0; p < N_PHASES; p++) begin : g_lamp
    assign lights[3*p +: 3] = (phase_q == PW'(p)) ? lamp : 3'b001;
  end

  assign fsm_state    = state_q;
  assign active_phase = phase_q;
  assign phase_start  = phase_start_q;

endmodule

// File: tb/tb_adaptive_phase_controller.sv
// Scoreboard bench for adaptive_phase_controller: directed scenarios plus randomized traffic,
// expected outputs from a behavioural model of the phase-visit rules.
module tb_adaptive_phase_controller;

  localparam int N    = 4;
  localparam int CW   = 8;
  localparam int MING = 4;
  localparam int MAXG = 8;
  localparam int YT   = 2;
  localparam int ART  = 1;

  logic        clk = 1'b0;
  logic        rst, tick;
  logic [3:0]  demand, congest;
  logic [1:0]  fsm_state;
  logic [1:0]  active_phase;
  logic [11:0] lights;
  logic        green_ext, phase_start;

  always #5 clk = ~clk;

  adaptive_phase_controller #(
    .N_PHASES(N), .CNT_W(CW), .MIN_GREEN(MING), .MAX_GREEN(MAXG), .YELLOW_T(YT), .ALLRED_T(ART)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .demand(demand), .congest(congest),
    .fsm_state(fsm_state), .active_phase(active_phase), .lights(lights),
    .green_ext(green_ext), .phase_start(phase_start)
  );

  typedef struct packed {
    logic [1:0]  st;
    logic [1:0]  ph;
    logic [11:0] li;
    logic        ge;
    logic        ps;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: mode 0 = all red, 1 = green, 2 = yellow; elapsed = ticks spent in the mode.
  int m_mode    = 0;
  int m_elapsed = 0;
  int m_phase   = N - 1;
  bit m_ps      = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    e.st = 2'(m_mode);
    e.ph = 2'(m_phase);
    for (int p = 0; p < N; p++) begin
      if (p == m_phase && m_mode == 1)      e.li[3*p +: 3] = 3'b010;
      else if (p == m_phase && m_mode == 2) e.li[3*p +: 3] = 3'b100;
      else                                  e.li[3*p +: 3] = 3'b001;
    end
    e.ge = (m_mode == 1) && (m_elapsed >= MING);
    e.ps = m_ps;
    return e;
  endfunction

  task automatic model_step(input bit r, input bit t, input logic [3:0] d, input logic [3:0] c);
    int nxt;
    if (r) begin
      m_mode = 0; m_elapsed = 0; m_phase = N - 1; m_ps = 1'b0;
      return;
    end
    m_ps = 1'b0;
    if (!t) return;
    nxt = m_elapsed + 1;
    if (m_mode == 0) begin
      if (nxt >= ART && d != 4'b0) begin
        for (int k = 1; k <= N; k++) begin
          if (((d >> ((m_phase + k) % N)) & 4'b1) != 4'b0) begin
            m_phase = (m_phase + k) % N;
            break;
          end
        end
        m_mode = 1; m_elapsed = 0; m_ps = 1'b1;
      end else begin
        m_elapsed = (nxt < ART) ? nxt : ART;
      end
    end else if (m_mode == 1) begin
      if (nxt >= MING && ((((c >> m_phase) & 4'b1) == 4'b0) || nxt >= MAXG)) begin
        m_mode = 2; m_elapsed = 0;
      end else begin
        m_elapsed = nxt;
      end
    end else begin
      if (nxt == YT) begin
        m_mode = 0; m_elapsed = 0;
      end else begin
        m_elapsed = nxt;
      end
    end
  endtask

  task automatic step(input bit r, input bit t, input logic [3:0] d, input logic [3:0] c);
    @(negedge clk);
    rst = r; tick = t; demand = d; congest = c;
    model_step(r, t, d, c);
    exp_q.push_back(model_out());
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Monitor: one output set per clock; also records green run lengths and served order.
  int green_cnt = 0;
  int last_green_len = 0;
  int served[$];
  int cyc = 0;

  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {fsm_state, active_phase, lights, green_ext, phase_start};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got st=%0d ph=%0d li=%h ge=%0b ps=%0b expected st=%0d ph=%0d li=%h ge=%0b ps=%0b",
                   cyc, a.st, a.ph, a.li, a.ge, a.ps, e.st, e.ph, e.li, e.ge, e.ps);
        end
      end
      if (fsm_state == 2'd1) green_cnt++;
      else begin
        if (green_cnt > 0) last_green_len = green_cnt;
        green_cnt = 0;
      end
      if (phase_start) served.push_back(int'(active_phase));
    end
  end

  initial begin
    int n;
    int greens;
    int base;
    int want[4];
    bit t;
    want = '{3, 0, 1, 3};
    rst = 1'b1; tick = 1'b0; demand = '0; congest = '0;

    // Reset, idle all-red, then a single demand on phase 2.
    repeat (3) step(1, 1, 4'b0, 4'b0);
    repeat (20) step(0, 1, 4'b0, 4'b0);
    check_int("idle_lights", int'(lights), 12'h249);
    step(0, 1, 4'b0100, 4'b0);

    // Phase 0 without congestion: minimum green.
    n = 0;
    while (!(m_mode == 1 && m_phase == 0) && n < 100) begin step(0, 1, 4'b0001, 4'b0); n++; end
    while (m_mode == 1 && n < 200) begin step(0, 1, 4'b0001, 4'b0); n++; end
    step(0, 1, 4'b0001, 4'b0);
    check_int("green_len_min", last_green_len, MING);

    // Congestion held on phase 0: green stretched to maximum.
    n = 0;
    while (m_mode != 1 && n < 100) begin step(0, 1, 4'b0001, 4'b0001); n++; end
    while (m_mode == 1 && n < 200) begin step(0, 1, 4'b0001, 4'b0001); n++; end
    step(0, 1, 4'b0001, 4'b0001);
    check_int("green_len_max", last_green_len, MAXG);

    // Round-robin with demand 1011 starting from phase 1.
    n = 0;
    while (!(m_mode == 1 && m_phase == 1) && n < 100) begin step(0, 1, 4'b0010, 4'b0); n++; end
    greens = 0;
    while (greens < 4 && n < 300) begin
      step(0, 1, 4'b1011, 4'b0);
      if (m_ps) greens++;
      n++;
    end
    step(0, 1, 4'b1011, 4'b0);
    step(0, 1, 4'b1011, 4'b0);
    if (served.size() < 4) check_int("served_count", served.size(), 4);
    else begin
      base = served.size() - 4;
      for (int i = 0; i < 4; i++) check_int($sformatf("served_order[%0d]", i), served[base + i], want[i]);
    end

    // Reset on green cycle 2.
    n = 0;
    while (!(m_mode == 1 && m_elapsed == 1) && n < 100) begin step(0, 1, 4'b0001, 4'b0); n++; end
    step(1, 1, 4'b0001, 4'b0);
    step(0, 0, 4'b0001, 4'b0);
    check_int("rst_state", int'(fsm_state), 0);
    check_int("rst_phase", int'(active_phase), 3);
    check_int("rst_lights", int'(lights), 12'h249);

    // Tick held low: everything frozen, including mid-green.
    n = 0;
    while (m_mode != 1 && n < 100) begin step(0, 1, 4'b0001, 4'b0); n++; end
    repeat (30) step(0, 0, 4'($urandom), 4'($urandom));

    // Tick every third cycle: green duration scales to 3*MIN_GREEN clocks.
    n = 0;
    while (m_mode == 1 && n < 300) begin t = (n % 3 == 0); step(0, t, 4'b0001, 4'b0); n++; end
    while (m_mode != 1 && n < 600) begin t = (n % 3 == 0); step(0, t, 4'b0001, 4'b0); n++; end
    while (m_mode == 1 && n < 900) begin t = (n % 3 == 0); step(0, t, 4'b0001, 4'b0); n++; end
    t = (n % 3 == 0);
    step(0, t, 4'b0001, 4'b0);
    check_int("green_len_slow", last_green_len, 3 * MING);

    // Randomized traffic, sparse ticks and rare resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0), (i < 300) ? 1'b1 : ($urandom_range(0, 2) == 0),
           4'($urandom), 4'($urandom));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin @(posedge clk); n++; end
    #2;
    check_int("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
